// File: rtl/clk_sel_ctrl_pkg.sv
// clk_sel_pkg: shared types and constants for the clock-select control stage.
// The heartbeat check is compiled in by defining CLK_SEL_HB_CHECK_EN.
package clk_sel_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    QUIESCE = 3'd2,
    SWITCH  = 3'd3,
    SETTLE  = 3'd4,
    RELEASE = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_QTO  = 2'd1;
  localparam logic [1:0] ERR_HBTO = 2'd2;

  // Bits needed for a counter that runs 0 .. max_count-1.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/clk_sel_ctrl_if.sv
// clk_sel_ctrl_if: request/status bundle between a requester and clk_sel_ctrl.
// Optional heartbeat check macro: CLK_SEL_HB_CHECK_EN (no effect on this file).
interface clk_sel_ctrl_if;
  logic       req_valid;
  logic       req_sel;
  logic       req_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output req_valid, req_sel,
    input  req_ready, busy, done, err, err_code
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, busy, done, err, err_code
  );
endinterface

// File: rtl/clk_sel_ctrl_hb_sync.sv
// clk_sel_hb_sync: synchronizes one toggle heartbeat into aclk and flags each toggle.
// Only instantiated when CLK_SEL_HB_CHECK_EN is defined.
module clk_sel_hb_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic hb_async,
  output logic hb_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Synchronizer chain plus one flop holding the previous synchronized value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], hb_async};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign hb_edge = sync_q[SYNC_STAGES-1] ^ last_q;

endmodule

// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: owns the glitch-free clock mux select; quiesces, flips, settles, releases.
// Define CLK_SEL_HB_CHECK_EN to confirm the target clock is toggling before switching.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// CHECK   | waiting for a heartbeat edge from the target clock (macro only)
// QUIESCE | quiesce_req high, waiting for quiesce_ack or timeout
// SWITCH  | one cycle, selection takes the target on exit
// SETTLE  | SETTLE_CYCLES cycles for the mux to finish switching
// RELEASE | one cycle, drops quiesce_req and reports done
module clk_sel_ctrl
  import clk_sel_pkg::*;
#(
  parameter logic RESET_SEL       = 1'b0,
  parameter int   SETTLE_CYCLES   = 16,
  parameter int   QUIESCE_TIMEOUT = 1024,
  parameter int   HB_WINDOW       = 256,
  parameter int   SYNC_STAGES     = 2
) (
  input  logic                aclk,
  input  logic                aresetn,
  clk_sel_ctrl_if.slave       ctl,
  output logic                selection,
  output logic                quiesce_req,
  input  logic                quiesce_ack,
  input  logic [1:0]          hb_in
);

  localparam int CNT_MAX_A = (SETTLE_CYCLES > QUIESCE_TIMEOUT) ? SETTLE_CYCLES : QUIESCE_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > HB_WINDOW) ? CNT_MAX_A : HB_WINDOW;
  localparam int CW        = cnt_width(CNT_MAX);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] QTO_LAST    = CW'(QUIESCE_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          target_q, target_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          ready_q, busy_q;
  logic          tgt_edge;

`ifdef CLK_SEL_HB_CHECK_EN
  localparam logic [CW-1:0] HB_LAST = CW'(HB_WINDOW - 1);
  logic [1:0] hb_edge;

  clk_sel_hb_sync #(.SYNC_STAGES(SYNC_STAGES)) u_hb_sync0 (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .hb_async (hb_in[0]),
    .hb_edge  (hb_edge[0])
  );

  clk_sel_hb_sync #(.SYNC_STAGES(SYNC_STAGES)) u_hb_sync1 (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .hb_async (hb_in[1]),
    .hb_edge  (hb_edge[1])
  );

  assign tgt_edge = hb_edge[target_q];
`else
  // Heartbeats are not monitored in this build.
  logic unused_hb;
  assign unused_hb = ^{hb_in, (SYNC_STAGES > 2)};
  assign tgt_edge  = 1'b0;
`endif

  // Next-state, counter and pulse decode.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sel_d    = selection;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    case (state_q)
      IDLE: begin
        if (ctl.req_valid && ready_q) begin
          target_d = ctl.req_sel;
          if (ctl.req_sel == selection) begin
            done_d = 1'b1;
          end else begin
`ifdef CLK_SEL_HB_CHECK_EN
            state_d = CHECK;
`else
            state_d = QUIESCE;
`endif
          end
        end
      end
`ifdef CLK_SEL_HB_CHECK_EN
      CHECK: begin
        if (tgt_edge) begin
          state_d = QUIESCE;
        end else if (cnt_q == HB_LAST) begin
          err_d   = 1'b1;
          code_d  = ERR_HBTO;
          state_d = IDLE;
        end
      end
`endif
      QUIESCE: begin
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (quiesce_ack) begin
          state_d = SWITCH;
        end else if (cnt_q == QTO_LAST) begin
          err_d   = 1'b1;
          code_d  = ERR_QTO;
          state_d = IDLE;
        end
      end
      SWITCH: begin
        sel_d   = target_q;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = RELEASE;
      end
      RELEASE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Every state timer starts from zero on entry and saturates.
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q != '1)   cnt_d = cnt_q + 1'b1;
    else                    cnt_d = cnt_q;
  end

  // State, timer and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      target_q    <= RESET_SEL;
      cnt_q       <= '0;
      selection   <= RESET_SEL;
      quiesce_req <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      selection   <= sel_d;
      quiesce_req <= (state_d == QUIESCE) || (state_d == SWITCH) ||
                     (state_d == SETTLE)  || (state_d == RELEASE);
      done_q      <= done_d;
      err_q       <= err_d;
      code_q      <= code_d;
      ready_q     <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign ctl.req_ready = ready_q;
  assign ctl.busy      = busy_q;
  assign ctl.done      = done_q;
  assign ctl.err       = err_q;
  assign ctl.err_code  = code_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb_clk_sel_ctrl: directed bench for clk_sel_ctrl (RESET_SEL=1, SETTLE=16, QTO=8, HB=32).
// Covers the heartbeat check when built with CLK_SEL_HB_CHECK_EN.
module tb_clk_sel_ctrl;

`ifdef CLK_SEL_HB_CHECK_EN
  localparam int X = 1;  // CHECK sees a live heartbeat in its first cycle
`else
  localparam int X = 0;
`endif

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       selection;
  logic       quiesce_req;
  logic       quiesce_ack;
  logic [1:0] hb_in = 2'b00;
  logic [1:0] hb_run;
  int         passed = 0;
  int         total  = 0;

  clk_sel_ctrl_if ctl ();

  clk_sel_ctrl #(
    .RESET_SEL       (1'b1),
    .SETTLE_CYCLES   (16),
    .QUIESCE_TIMEOUT (8),
    .HB_WINDOW       (32),
    .SYNC_STAGES     (2)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .ctl         (ctl),
    .selection   (selection),
    .quiesce_req (quiesce_req),
    .quiesce_ack (quiesce_ack),
    .hb_in       (hb_in)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) hb_in <= hb_in ^ hb_run;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic send(input logic sel);
    ctl.req_valid = 1'b1;
    ctl.req_sel   = sel;
    tick;
    ctl.req_valid = 1'b0;
  endtask

  task automatic wait_done;
    int n = 0;
    while (ctl.done !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    chk("done_seen", ctl.done, 1'b1);
  endtask

  // Full-timing switch with ack already high; a request dropped mid-flight.
  task automatic run_switch(input logic tgt, input logic old);
    send(tgt);
    for (int c = 1; c <= 21 + X; c++) begin
      chk("sw_qreq",  quiesce_req,   (c >= 1 + X && c <= 19 + X));
      chk("sw_sel",   selection,     (c >= 3 + X) ? tgt : old);
      chk("sw_done",  ctl.done,      (c == 20 + X));
      chk("sw_busy",  ctl.busy,      (c <= 19 + X));
      chk("sw_ready", ctl.req_ready, (c >= 20 + X));
      chk("sw_err",   ctl.err,       1'b0);
      ctl.req_valid = (c == 5);
      ctl.req_sel   = ~tgt;
      tick;
    end
    ctl.req_valid = 1'b0;
  endtask

  initial begin
    aresetn       = 1'b0;
    ctl.req_valid = 1'b0;
    ctl.req_sel   = 1'b0;
    quiesce_ack   = 1'b0;
    hb_run        = 2'b11;
    tick;
    tick;
    chk("rst_sel",   selection,     1'b1);
    chk("rst_ready", ctl.req_ready, 1'b1);
    chk("rst_busy",  ctl.busy,      1'b0);
    chk("rst_done",  ctl.done,      1'b0);
    chk("rst_err",   ctl.err,       1'b0);
    chk("rst_code",  ctl.err_code,  2'd0);
    chk("rst_qreq",  quiesce_req,   1'b0);
    aresetn = 1'b1;
    repeat (3) tick;

    quiesce_ack = 1'b1;
    run_switch(1'b0, 1'b1);
    run_switch(1'b1, 1'b0);

    // Request for the current select completes immediately.
    send(1'b1);
    chk("eq_done",  ctl.done,    1'b1);
    chk("eq_qreq",  quiesce_req, 1'b0);
    chk("eq_busy",  ctl.busy,    1'b0);
    chk("eq_sel",   selection,   1'b1);
    tick;
    chk("eq_done2", ctl.done,    1'b0);
    chk("eq_qreq2", quiesce_req, 1'b0);

    // Quiesce timeout after 8 QUIESCE cycles.
    quiesce_ack = 1'b0;
    send(1'b0);
    for (int c = 1; c <= 8 + X; c++) begin
      chk("qto_qreq", quiesce_req, (c >= 1 + X));
      chk("qto_err",  ctl.err,     1'b0);
      tick;
    end
    chk("qto_err1",  ctl.err,      1'b1);
    chk("qto_code",  ctl.err_code, 2'd1);
    chk("qto_qreq0", quiesce_req,  1'b0);
    chk("qto_sel",   selection,    1'b1);
    chk("qto_busy",  ctl.busy,     1'b0);
    tick;
    chk("qto_err0",  ctl.err,      1'b0);
    chk("qto_hold",  ctl.err_code, 2'd1);

    // Ack arriving in the timeout cycle wins.
    send(1'b0);
    repeat (7 + X) tick;
    quiesce_ack = 1'b1;
    tick;
    chk("aw_err",  ctl.err,     1'b0);
    chk("aw_qreq", quiesce_req, 1'b1);
    chk("aw_busy", ctl.busy,    1'b1);
    tick;
    chk("aw_sel",  selection,   1'b0);
    wait_done;
    chk("aw_code", ctl.err_code, 2'd1);

`ifdef CLK_SEL_HB_CHECK_EN
    // Static heartbeat on clock input 1: heartbeat timeout after 32 CHECK cycles.
    hb_run[1] = 1'b0;
    repeat (6) tick;
    send(1'b1);
    for (int c = 1; c <= 32; c++) begin
      chk("hb_busy", ctl.busy,    1'b1);
      chk("hb_qreq", quiesce_req, 1'b0);
      chk("hb_err",  ctl.err,     1'b0);
      tick;
    end
    chk("hb_err1", ctl.err,      1'b1);
    chk("hb_code", ctl.err_code, 2'd2);
    chk("hb_sel",  selection,    1'b0);
    chk("hb_idle", ctl.busy,     1'b0);
    hb_run[1] = 1'b1;
    repeat (6) tick;
`endif
    send(1'b1);
    wait_done;
    chk("re_sel", selection, 1'b1);

    // Reset during SETTLE returns outputs immediately.
    send(1'b0);
    repeat (5 + X) tick;
    chk("st_sel",  selection,   1'b0);
    chk("st_qreq", quiesce_req, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("ar_sel",   selection,     1'b1);
    chk("ar_qreq",  quiesce_req,   1'b0);
    chk("ar_busy",  ctl.busy,      1'b0);
    chk("ar_ready", ctl.req_ready, 1'b1);
    chk("ar_done",  ctl.done,      1'b0);
    tick;
    aresetn = 1'b1;
    repeat (3) tick;
    chk("post_sel",  selection, 1'b1);
    chk("post_busy", ctl.busy,  1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
